// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: byte-enable encodings and defaults.
// No logic of its own; the helper expands lane enables to a bit mask.
// Imported by the store buffer top and its forwarding merge.
package store_buffer_pkg;

    localparam int SB_DEPTH_DEF = 4;
    localparam int SB_AW_DEF    = 32;

    localparam logic [3:0] BE_WORD  = 4'b1111;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;

    // Expand 4 lane enables into a 32-bit bit mask (lane i -> bits [8i+7:8i]).
    function automatic logic [31:0] be_lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// Store-to-load forwarding: per-lane select of the youngest matching buffered store.
// Purely combinational, zero cycles.
// No flow control; result is valid every cycle whether or not a load is present.
module sb_fwd_merge
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEF,
    parameter int AW    = SB_AW_DEF
) (
    input  logic [AW-3:0]              ent_addr [DEPTH],
    input  logic [31:0]                ent_data [DEPTH],
    input  logic [3:0]                 ent_be   [DEPTH],
    input  logic [DEPTH-1:0]           ent_vld,
    input  logic [$clog2(DEPTH)-1:0]   head_ptr,
    input  logic [AW-1:0]              ld_addr,
    output logic [3:0]                 ld_fwd_mask,
    output logic [31:0]                ld_fwd_data
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;
    logic [31:0]   lane;

    // Byte offset of the load is irrelevant: matching is on the word address.
    logic unused_ld_lo;
    assign unused_ld_lo = ^ld_addr[1:0];

    // Walk entries oldest (head) to youngest; later hits overwrite earlier lanes.
    always_comb begin
        ld_fwd_mask = '0;
        ld_fwd_data = '0;
        idx         = '0;
        lane        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_ptr + PW'(k);
            if (ent_vld[idx] && (ent_addr[idx] == ld_addr[AW-1:2])) begin
                lane        = be_lane_mask(ent_be[idx]);
                ld_fwd_data = (ld_fwd_data & ~lane) | (ent_data[idx] & lane);
                ld_fwd_mask = ld_fwd_mask | ent_be[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store queue ahead of the data-memory write port, with load forwarding.
// Enqueue at edge N, earliest drain at edge N+1; one drain per cycle when no load.
// in_ready drops only when full (a same-cycle drain does not free a slot); loads stall draining.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEF,
    parameter int AW    = SB_AW_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [31:0]              in_wdata,
    input  logic [3:0]               in_be,
    input  logic [31:0]              in_pc,
    input  logic                     ld_req,
    input  logic [AW-1:0]            ld_addr,
    output logic [3:0]               ld_fwd_mask,
    output logic [31:0]              ld_fwd_data,
    output logic                     dm_we,
    output logic [AW-1:0]            dm_addr,
    output logic [31:0]              dm_wdata,
    output logic [3:0]               dm_be,
    output logic [31:0]              dm_wpc,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [AW-3:0]    addr_q [DEPTH];
    logic [AW-3:0]    addr_d [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [3:0]       be_d   [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      pc_d   [DEPTH];

    logic enq;

    // Low address bits are dropped: entries are word-aligned.
    logic unused_in_lo;
    assign unused_in_lo = ^in_addr[1:0];

    // Handshake, drain strobe, and next-state for pointers, count and entries.
    always_comb begin
        in_ready = (count_q != FULL_CNT);
        empty    = (count_q == '0);
        count    = count_q;
        // Reset cycle must never commit a write to memory.
        dm_we    = !empty && !ld_req && !reset;
        dm_addr  = {addr_q[head_q], 2'b00};
        dm_wdata = data_q[head_q];
        dm_be    = be_q[head_q];
        dm_wpc   = pc_q[head_q];

        // A zero-enable store completes the handshake but queues nothing.
        enq = in_valid && in_ready && (in_be != 4'b0000);

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        vld_d   = vld_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        pc_d    = pc_q;

        if (enq) begin
            addr_d[tail_q] = in_addr[AW-1:2];
            data_d[tail_q] = in_wdata;
            be_d[tail_q]   = in_be;
            pc_d[tail_q]   = in_pc;
            vld_d[tail_q]  = 1'b1;
            tail_d         = tail_q + PW'(1);
        end
        if (dm_we) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PW'(1);
        end
        case ({enq, dm_we})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: cleared by reset, which discards all pending stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    // Entry payload: qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        be_q   <= be_d;
        pc_q   <= pc_d;
    end

    sb_fwd_merge #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fwd (
        .ent_addr    (addr_q),
        .ent_data    (data_q),
        .ent_be      (be_q),
        .ent_vld     (vld_q),
        .head_ptr    (head_q),
        .ld_addr     (ld_addr),
        .ld_fwd_mask (ld_fwd_mask),
        .ld_fwd_data (ld_fwd_data)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a write-order scoreboard.
// Expected writes are queued at handshake time and popped when dm_we fires.
// Forwarding and reset behaviour are checked against constants.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [3:0]  in_be;
    logic [31:0] in_pc;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [3:0]  ld_fwd_mask;
    logic [31:0] ld_fwd_data;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_wpc;
    logic        empty;
    logic [2:0]  count;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] pc;
    } wr_t;

    wr_t sb_q[$];
    int  errors    = 0;
    int  checks    = 0;
    int  model_cnt = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_be       (in_be),
        .in_pc       (in_pc),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_fwd_mask (ld_fwd_mask),
        .ld_fwd_data (ld_fwd_data),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_be       (dm_be),
        .dm_wpc      (dm_wpc),
        .empty       (empty),
        .count       (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: compare at negedge against the model, then advance to posedge+1.
    task automatic cycle();
        logic drn;
        logic acc;
        wr_t  e;
        @(negedge clk);
        drn = (model_cnt != 0) && !ld_req;
        acc = in_valid && (model_cnt != DEPTH);
        chk("in_ready", in_ready, model_cnt != DEPTH);
        chk("count", count, model_cnt);
        chk("empty", empty, model_cnt == 0);
        chk("dm_we", dm_we, drn);
        if (drn && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("dm_addr", dm_addr, e.addr);
            chk("dm_wdata", dm_wdata, e.data);
            chk("dm_be", dm_be, e.be);
            chk("dm_wpc", dm_wpc, e.pc);
        end
        if (acc && in_be != 4'b0000) begin
            sb_q.push_back('{addr: {in_addr[31:2], 2'b00}, data: in_wdata, be: in_be, pc: in_pc});
            model_cnt++;
        end
        if (drn) model_cnt--;
        @(posedge clk);
        #1;
    endtask

    // Offer a store and hold it until the model says it was accepted.
    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] pc);
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_addr  = a;
        in_wdata = d;
        in_be    = be;
        in_pc    = pc;
        for (int n = 0; n < 40 && !done; n++) begin
            done = (model_cnt != DEPTH);
            cycle();
        end
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL put_timeout observed=not_accepted expected=accepted");
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain_all();
        ld_req = 1'b0;
        for (int n = 0; n < 40 && model_cnt != 0; n++) cycle();
        chk("drained", count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_addr  = '0;
        in_wdata = '0;
        in_be    = '0;
        in_pc    = '0;
        ld_req   = 1'b0;
        ld_addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_dm_we", dm_we, 0);
        chk("rst_fwd_mask", ld_fwd_mask, 0);
        chk("rst_fwd_data", ld_fwd_data, 0);

        // Single store drains on the following cycle
        put(32'h10, 32'hDEADBEEF, 4'b1111, 32'h3000);
        idle(1);
        chk("single_empty_after", empty, 1);
        idle(2);

        // Fill while loads hold the port; fifth store is refused until a drain
        ld_req = 1'b1;
        for (int i = 0; i < 4; i++)
            put(32'h100 + 32'(4*i), 32'hA0000000 + 32'(i), 4'b1111, 32'h4000 + 32'(4*i));
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_addr  = 32'h200;
        in_wdata = 32'h55667788;
        in_be    = 4'b1111;
        in_pc    = 32'h4100;
        idle(3);
        ld_req = 1'b0;
        put(32'h200, 32'h55667788, 4'b1111, 32'h4100);
        drain_all();

        // Youngest entry wins per lane
        ld_req = 1'b1;
        put(32'h20, 32'h11223344, 4'b1111, 32'h5000);
        put(32'h20, 32'h0000AA00, 4'b0010, 32'h5004);
        ld_addr = 32'h22;
        #1;
        chk("fwd_mask_merge", ld_fwd_mask, 4'b1111);
        chk("fwd_data_merge", ld_fwd_data, 32'h1122AA44);
        drain_all();

        // Same-cycle enqueue is not forwarded; other word does not match
        ld_req   = 1'b1;
        in_valid = 1'b1;
        in_addr  = 32'h40;
        in_wdata = 32'h000000FF;
        in_be    = 4'b0001;
        in_pc    = 32'h6000;
        ld_addr  = 32'h40;
        #1;
        chk("fwd_same_cycle_mask", ld_fwd_mask, 0);
        put(32'h40, 32'h000000FF, 4'b0001, 32'h6000);
        ld_addr = 32'h44;
        #1;
        chk("fwd_miss_mask", ld_fwd_mask, 0);
        chk("fwd_miss_data", ld_fwd_data, 0);
        ld_addr = 32'h43;
        #1;
        chk("fwd_byte_mask", ld_fwd_mask, 4'b0001);
        chk("fwd_byte_data", ld_fwd_data, 32'h000000FF);
        drain_all();

        // Reset with pending stores discards them
        ld_req = 1'b1;
        put(32'h80, 32'h01010101, 4'b1111, 32'h7000);
        put(32'h84, 32'h02020202, 4'b1111, 32'h7004);
        put(32'h88, 32'h03030303, 4'b1111, 32'h7008);
        chk("pre_reset_count", count, 3);
        ld_req = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        chk("reset_cycle_dm_we", dm_we, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        model_cnt = 0;
        chk("post_reset_count", count, 0);
        chk("post_reset_empty", empty, 1);
        chk("post_reset_in_ready", in_ready, 1);
        ld_addr = 32'h80;
        #1;
        chk("post_reset_fwd_mask", ld_fwd_mask, 0);
        idle(4);

        // Zero-enable store: accepted, nothing queued, nothing written
        in_valid = 1'b1;
        in_addr  = 32'h90;
        in_wdata = 32'hFFFFFFFF;
        in_be    = 4'b0000;
        in_pc    = 32'h8000;
        #1;
        chk("be0_in_ready", in_ready, 1);
        cycle();
        in_valid = 1'b0;
        chk("be0_count", count, 0);
        idle(3);

        // Wrap pointers past DEPTH with mixed enables
        for (int i = 0; i < 6; i++)
            put(32'h300 + 32'(4*i), 32'hC0DE0000 + 32'(i), (i % 2 == 0) ? 4'b0011 : 4'b1100,
                32'h9000 + 32'(4*i));
        drain_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
